// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types for the PC sequencer: control opcodes, sequencer states and the
// bit positions of the Z/N flags inside one ALU flag lane.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_COM  = 4'b0001,
        OP_END  = 4'b0010,
        OP_CALL = 4'b1000,
        OP_RET  = 4'b1001,
        OP_JNE  = 4'b1010,
        OP_JGE  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_JEQ  = 4'b1101,
        OP_JLT  = 4'b1110
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Fetch-side bundle of the PC sequencer. Parameters I (PC width), N (immediate
// width) and R (flag lanes) must match the pc_sequencer instance.
//   inputs to sequencer : start, Stall, FlagsW, ALUFlags[2R], Lane, Id[4],
//                         Imm[N], ComAck
//   outputs             : PCNext[I], Running, EndFlag, COMFlag, StackErr
// modport master drives the inputs (decode/testbench), slave is the sequencer.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int I = 32,
    parameter int N = 8,
    parameter int R = 6
);
    localparam int LW = (R > 1) ? $clog2(R) : 1;

    logic            start;
    logic            Stall;
    logic            FlagsW;
    logic [2*R-1:0]  ALUFlags;
    logic [LW-1:0]   Lane;
    logic [3:0]      Id;
    logic [N-1:0]    Imm;
    logic            ComAck;
    logic [I-1:0]    PCNext;
    logic            Running;
    logic            EndFlag;
    logic            COMFlag;
    logic            StackErr;

    modport master (
        output start, Stall, FlagsW, ALUFlags, Lane, Id, Imm, ComAck,
        input  PCNext, Running, EndFlag, COMFlag, StackErr
    );

    modport slave (
        input  start, Stall, FlagsW, ALUFlags, Lane, Id, Imm, ComAck,
        output PCNext, Running, EndFlag, COMFlag, StackErr
    );
endinterface

// File: rtl/flopenr.sv
// -----------------------------------------------------------------------------
// flopenr
// Enabled register with asynchronous active-low reset to zero.
//   clk, reset (active-low), en, d[WIDTH] -> q[WIDTH]
// -----------------------------------------------------------------------------
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/pc_sequencer_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// Hardware return-address LIFO of D entries of I bits.
//   clk, reset (async active-low, clears sp), clr (sync sp clear),
//   push/din[I] writes stack[sp] then sp++, pop reads stack[sp-1] then sp--,
//   dout[I] = stack[sp-1], full (sp==D), empty (sp==0).
// Push while full and pop while empty are ignored; the caller traps them.
// -----------------------------------------------------------------------------
module ret_stack #(
    parameter int D = 4,
    parameter int I = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [I-1:0] din,
    output logic [I-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int SW = $clog2(D + 1);
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [SW-1:0] sp;
    logic [I-1:0]  mem [2**AW];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // sp < D whenever a write happens and sp > 0 whenever a read is used,
    // so truncating to the storage index width is lossless.
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - SW'(1));
    assign full   = (sp == SW'(D));
    assign empty  = (sp == '0);
    assign dout   = mem[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               sp <= '0;
        else if (clr)             sp <= '0;
        else if (push && !full)   sp <= sp + SW'(1);
        else if (pop && !empty)   sp <= sp - SW'(1);
    end

    // Storage carries no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= din;
    end
endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program-counter sequencer with IDLE/RUN/HALT control, per-lane
// flag selection, conditional branches, CALL/RET on a hardware return stack
// and sticky END / COM / stack-error status.
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   bus (slave)    start, Stall, FlagsW, ALUFlags, Lane, Id, Imm, ComAck in;
//                  PCNext, Running, EndFlag, COMFlag, StackErr out
// Optional build macro PCSEQ_REL_BRANCH_EN: jump/call targets become
// PCNext + sign-extended Imm instead of zero-extended absolute Imm.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int I    = 32,
    parameter int N    = 8,
    parameter int R    = 6,
    parameter int D    = 4,
    parameter int STEP = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int LW = (R > 1) ? $clog2(R) : 1;

    state_e         state_q, state_d;
    logic [I-1:0]   pc_q, pc_d;
    logic           end_q, end_d;
    logic           com_q, com_d;
    logic           err_q, err_d;
    logic [2*R-1:0] flags_q;
    logic [1:0]     f;
    logic [I-1:0]   seq, tgt, top;
    logic           push, pop, clr, full, empty;

    flopenr #(.WIDTH(2*R)) u_flags (
        .clk   (clk),
        .reset (reset),
        .en    (bus.FlagsW),
        .d     (bus.ALUFlags),
        .q     (flags_q)
    );

    ret_stack #(.D(D), .I(I)) u_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .dout  (top),
        .full  (full),
        .empty (empty)
    );

    assign seq = pc_q + I'(STEP);
`ifdef PCSEQ_REL_BRANCH_EN
    assign tgt = pc_q + {{(I-N){bus.Imm[N-1]}}, bus.Imm};
`else
    assign tgt = {{(I-N){1'b0}}, bus.Imm};
`endif

    // Lane mux over the latched flags; an out-of-range lane reads as {N,Z}=0.
    always_comb begin
        f = 2'b00;
        for (int i = 0; i < R; i++) begin
            if (bus.Lane == LW'(i)) f = flags_q[2*i +: 2];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        err_d   = err_q;
        com_d   = bus.ComAck ? 1'b0 : com_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_HALT: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    clr     = 1'b1;
                    end_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.Stall) begin
                    case (bus.Id)
                        OP_NOP: pc_d = seq;
                        OP_COM: begin
                            pc_d  = seq;
                            com_d = 1'b1;   // overrides a same-cycle ComAck
                        end
                        OP_END: begin
                            end_d   = 1'b1;
                            state_d = S_HALT;
                        end
                        OP_CALL: begin
                            if (full) begin
                                err_d   = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                push = 1'b1;
                                pc_d = tgt;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                err_d   = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                pop  = 1'b1;
                                pc_d = top;
                            end
                        end
                        OP_JNE:  pc_d = f[FLAG_Z] ? seq : tgt;
                        OP_JGE:  pc_d = f[FLAG_N] ? seq : tgt;
                        OP_JMP:  pc_d = tgt;
                        OP_JEQ:  pc_d = f[FLAG_Z] ? tgt : seq;
                        OP_JLT:  pc_d = f[FLAG_N] ? tgt : seq;
                        default: pc_d = seq;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            end_q   <= 1'b0;
            com_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            com_q   <= com_d;
            err_q   <= err_d;
        end
    end

    assign bus.PCNext   = pc_q;
    assign bus.Running  = (state_q == S_RUN);
    assign bus.EndFlag  = end_q;
    assign bus.COMFlag  = com_q;
    assign bus.StackErr = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// multi-cycle sequences (stack overflow, END freeze, stall, flag timing,
// asynchronous reset) and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
    localparam int I = 32, N = 8, R = 6, D = 4, STEP = 4;
    localparam int NOP = 0, COM = 1, ENDOP = 2, CALL = 8, RET = 9;
    localparam int JNE = 10, JGE = 11, JMP = 12, JEQ = 13, JLT = 14;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_HALT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pc_sequencer_if #(.I(I), .N(N), .R(R)) bus ();

    pc_sequencer #(.I(I), .N(N), .R(R), .D(D), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference model
    logic [31:0] m_pc;
    int          m_st;
    logic [31:0] m_stk[$];
    logic [1:0]  m_fl [R];
    bit          m_end, m_com, m_err;

    typedef struct {
        int start, stall, flagsw, alu, lane, id, imm, ack;
        int exp_pc, exp_run, exp_end, exp_com, exp_err;
    } vec_t;
    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_st  = ST_IDLE;
        m_stk.delete();
        for (int i = 0; i < R; i++) m_fl[i] = 2'b00;
        m_end = 1'b0;
        m_com = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] seq, tgt;
        logic [1:0]  f;
        int          ln, op;
        if (!reset) return;
        seq = m_pc + 32'(STEP);
`ifdef PCSEQ_REL_BRANCH_EN
        tgt = m_pc + {{24{bus.Imm[7]}}, bus.Imm};
`else
        tgt = {24'h0, bus.Imm};
`endif
        ln = int'(bus.Lane);
        f  = (ln < R) ? m_fl[ln] : 2'b00;
        op = int'(bus.Id);
        if (bus.ComAck) m_com = 1'b0;
        if (m_st == ST_RUN && !bus.Stall) begin
            case (op)
                COM:   begin m_pc = seq; m_com = 1'b1; end
                ENDOP: begin m_end = 1'b1; m_st = ST_HALT; end
                CALL: begin
                    if (m_stk.size() >= D) begin m_err = 1'b1; m_st = ST_HALT; end
                    else begin m_stk.push_back(seq); m_pc = tgt; end
                end
                RET: begin
                    if (m_stk.size() == 0) begin m_err = 1'b1; m_st = ST_HALT; end
                    else m_pc = m_stk.pop_back();
                end
                JNE:     m_pc = (f[0] == 1'b0) ? tgt : seq;
                JGE:     m_pc = (f[1] == 1'b0) ? tgt : seq;
                JMP:     m_pc = tgt;
                JEQ:     m_pc = (f[0] == 1'b1) ? tgt : seq;
                JLT:     m_pc = (f[1] == 1'b1) ? tgt : seq;
                default: m_pc = seq;
            endcase
        end else if (m_st == ST_IDLE && bus.start) begin
            m_st = ST_RUN;
        end else if (m_st == ST_HALT && bus.start) begin
            m_st  = ST_RUN;
            m_pc  = '0;
            m_stk.delete();
            m_end = 1'b0;
            m_err = 1'b0;
        end
        if (bus.FlagsW) for (int i = 0; i < R; i++) m_fl[i] = bus.ALUFlags[2*i +: 2];
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_pc"},  bus.PCNext, m_pc);
        check({tag, "_run"}, 32'(bus.Running), 32'(m_st == ST_RUN));
        check({tag, "_end"}, 32'(bus.EndFlag), 32'(m_end));
        check({tag, "_com"}, 32'(bus.COMFlag), 32'(m_com));
        check({tag, "_err"}, 32'(bus.StackErr), 32'(m_err));
    endtask

    task automatic drive(input int st, input int sl, input int fw, input int alu,
                         input int ln, input int id, input int imm, input int ack);
        bus.start    = (st != 0);
        bus.Stall    = (sl != 0);
        bus.FlagsW   = (fw != 0);
        bus.ALUFlags = alu[11:0];
        bus.Lane     = ln[2:0];
        bus.Id       = id[3:0];
        bus.Imm      = imm[7:0];
        bus.ComAck   = (ack != 0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic check_const(input string tag, input int pc, input int run,
                               input int en, input int cm, input int er);
        check({tag, "_pc"},  bus.PCNext, pc);
        check({tag, "_run"}, 32'(bus.Running), run);
        check({tag, "_end"}, 32'(bus.EndFlag), en);
        check({tag, "_com"}, 32'(bus.COMFlag), cm);
        check({tag, "_err"}, 32'(bus.StackErr), er);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        //            start stall fw  alu     lane id    imm   ack   pc     run end com err
        vecs[0]  = '{1, 0, 0, 0,      0, NOP,  0,    0,   'h00,  1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0,      0, NOP,  0,    0,   'h04,  1, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0,      0, NOP,  0,    0,   'h08,  1, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,      0, NOP,  0,    0,   'h0C,  1, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 'h040,  0, NOP,  0,    0,   'h10,  1, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0,      3, JEQ,  'h40, 0,   'h40,  1, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,      3, JNE,  'h80, 0,   'h44,  1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,      0, JMP,  'h08, 0,   'h08,  1, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0,      0, CALL, 'h20, 0,   'h20,  1, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0,      0, CALL, 'h30, 0,   'h30,  1, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0,      0, RET,  0,    0,   'h24,  1, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0,      0, RET,  0,    0,   'h0C,  1, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0,      0, RET,  0,    0,   'h0C,  0, 0, 0, 1};
        vecs[13] = '{1, 0, 0, 0,      0, NOP,  0,    0,   'h00,  1, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0,      0, COM,  0,    1,   'h04,  1, 0, 1, 0};
        vecs[15] = '{0, 0, 0, 0,      0, NOP,  0,    1,   'h08,  1, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0,      0, ENDOP, 0,   0,   'h08,  0, 1, 0, 0};

        drive(0, 0, 0, 0, 0, NOP, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_const("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        repeat (5) begin
            tick("idle");
            check_const("idle", 0, 0, 0, 0, 0);
        end

        for (int k = 0; k < 17; k++) begin
            drive(vecs[k].start, vecs[k].stall, vecs[k].flagsw, vecs[k].alu,
                  vecs[k].lane, vecs[k].id, vecs[k].imm, vecs[k].ack);
            tick($sformatf("vec%0d_m", k));
            check_const($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_run,
                        vecs[k].exp_end, vecs[k].exp_com, vecs[k].exp_err);
        end

        // END holds the PC and ignores opcodes while halted
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 0, JMP, int'($urandom_range(0, 255)), 0);
            tick("halt_m");
            check_const("end_freeze", 'h08, 0, 1, 0, 0);
        end

        // Restart, then D+1 nested CALLs overflow the return stack
        drive(1, 0, 0, 0, 0, NOP, 0, 0);
        tick("restart1_m");
        check_const("restart1", 0, 1, 0, 0, 0);
        for (int c = 1; c <= D + 1; c++) begin
            drive(0, 0, 0, 0, 0, CALL, 16 * c, 0);
            tick("ovf_m");
            if (c <= D) check_const($sformatf("call%0d", c), 16 * c, 1, 0, 0, 0);
            else        check_const("overflow", 'h40, 0, 0, 0, 1);
        end
        drive(1, 0, 0, 0, 0, NOP, 0, 0);
        tick("restart2_m");
        check_const("restart2", 0, 1, 0, 0, 0);

        // Stall freezes a JMP (and a COM) until released
        drive(0, 0, 0, 0, 0, NOP, 0, 0);
        tick("pre_stall_m");
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 0, (k == 1) ? COM : JMP, 'h60, 0);
            tick("stall_m");
            check_const($sformatf("stall%0d", k), 'h04, 1, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, JMP, 'h60, 0);
        tick("unstall_m");
        check_const("unstall", 'h60, 1, 0, 0, 0);

        // Branch in the same cycle as FlagsW sees the old flags
        drive(0, 0, 1, 'h010, 2, NOP, 0, 0);
        tick("flg1_m");
        check_const("flg_latch", 'h64, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 2, JEQ, 'h90, 0);
        tick("flg2_m");
        check_const("flg_old", 'h90, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 2, JEQ, 'hA0, 0);
        tick("flg3_m");
        check_const("flg_new", 'h94, 1, 0, 0, 0);

        // Asynchronous reset mid-RUN clears outputs without a clock edge
        drive(0, 0, 0, 0, 0, COM, 0, 0);
        tick("precom_m");
        check_const("precom", 'h98, 1, 0, 1, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_const("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            int r, id;
            r  = int'($urandom_range(0, 19));
            id = (r < 16) ? r : NOP;
            drive((($urandom_range(0, 5)) == 0) ? 1 : 0,
                  (($urandom_range(0, 3)) == 0) ? 1 : 0,
                  (($urandom_range(0, 2)) == 0) ? 1 : 0,
                  int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, R - 1)),
                  id,
                  int'($urandom_range(0, 255)),
                  (($urandom_range(0, 3)) == 0) ? 1 : 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter sequencer for the RSA pipeline CPU.
- Sits at fetch: takes decoded control-class Id, immediate and ALU flags; produces the registered PC plus run/halt/communication status.
- Adds to the previous PC control block:
  - explicit IDLE/RUN/HALT state machine with start and stall handling;
  - per-lane flag selection;
  - negated/compound branches;
  - CALL/RET with a hardware return stack and error trapping.

Parameters:
- I, 32, PC width in bits.
- N, 8, immediate width; zero-extended to I (sign-extended under the optional feature).
- R, 6, number of ALU flag lanes; each lane is {N,Z}, with bit0=Z and bit1=N.
- D, 4, return-stack depth (≥1).
- STEP, 4, PC increment per sequential instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begins or restarts execution from IDLE/HALT.
- Stall  in  1  holds PC and all state in RUN; has no effect in IDLE/HALT.
- FlagsW  in  1  latch all R flag lanes this cycle.
- ALUFlags  in  R×2  per-lane {N,Z}.
- Lane  in  $clog2(R) (min 1)  lane tested by conditional branches.
- Id  in  4  control opcode.
- Imm  in  N  branch/call target.
- ComAck  in  1  clears COMFlag.
- PCNext  out  I  registered PC.
- Running  out  1  state==RUN.
- EndFlag  out  1  registered; set on END, sticky.
- COMFlag  out  1  registered; sticky until ComAck.
- StackErr  out  1  registered; sticky; set on stack overflow/underflow.

Behaviour:
- Reset values (async, reset low): PCNext=0, state=IDLE, all flags=0, sp=0, EndFlag=0, COMFlag=0, StackErr=0, Running=0.
- States:
  - IDLE: PC held; Id ignored. start=1 → RUN next edge; PC stays 0.
  - RUN: Id decoded each non-stalled cycle; PC updates on the next edge (1-cycle latency). start ignored.
  - HALT: PC held; Id ignored. start=1 → RUN, PCNext=0, sp=0, and EndFlag/StackErr cleared on the same edge.
- Opcodes in RUN (tgt = Imm zero-extended to I; seq = PCNext+STEP, wraps modulo 2^I; F = latched flags[Lane]):
  - 0000 NOP: seq.
  - 0001 COM: seq; set COMFlag.
  - 0010 END: hold PC; EndFlag=1; → HALT.
  - 1000 CALL: push seq, PC=tgt. If sp==D: no push, StackErr=1, PC held, → HALT.
  - 1001 RET: pop, PC=stack[sp-1]. If sp==0: StackErr=1, PC held, → HALT.
  - 1010 JNE: tgt if !F.Z, else seq.
  - 1011 JGE: tgt if !F.N, else seq.
  - 1100 JMP: tgt.
  - 1101 JEQ: tgt if F.Z, else seq.
  - 1110 JLT: tgt if F.N, else seq.
  - others: seq.
- Flags:
  - FlagsW latches all lanes at the edge, independent of state and Stall.
  - A branch in the same cycle as FlagsW uses the old (pre-edge) flags.
- COMFlag:
  - Set by COM, cleared by ComAck.
  - COM and ComAck in the same cycle → COMFlag=1 (set wins).
  - A stalled COM does not set COMFlag.
- Stack: LIFO of D entries of I bits. Push writes stack[sp], then sp++. Pop reads stack[sp-1], then sp--. Only the sp==0 and sp==D boundaries are errors.
- Stall=1 in RUN: nothing changes except flag latching and ComAck clearing.
- Reset asserted mid-operation: immediate return to reset values; stack contents are don't-care.

Optional Feature:
- Macro PCSEQ_REL_BRANCH_EN.
- Defined: JMP/JEQ/JLT/JNE/JGE/CALL targets are PCNext + sign-extended Imm (relative, modulo 2^I). CALL still pushes seq.
- Undefined: all targets are absolute zero-extended Imm, as specified above.

Decomposition:
- Package pc_seq_pkg:
  - enum of 4-bit opcodes (OP_NOP, OP_COM, OP_END, OP_CALL, OP_RET, OP_JNE, OP_JGE, OP_JMP, OP_JEQ, OP_JLT);
  - state enum (S_IDLE, S_RUN, S_HALT);
  - flag bit indices FLAG_Z=0, FLAG_N=1.
- Sub-module ret_stack (parameters D, I): push/pop/full/empty, async active-low reset, holding sp and storage.
- Reuse flopenr for the flag register.

Test Plan:
- Reset low, then high with start=0 for 5 cycles → PCNext=0, Running=0. Pulse start, then NOPs → PC sequence 0,4,8,12.
- FlagsW with lane 3 = {N=0,Z=1}, Lane=3, JEQ Imm=0x40 → PCNext=0x40. Then JNE Imm=0x80 → PCNext=0x44.
- CALL 0x20 at PC=8, CALL 0x30, RET, RET → PC 0x20, 0x30, 0x24, 0x0C; sp returns to 0.
- D+1 nested CALLs → StackErr=1, state HALT, PC frozen at the (D+1)th CALL address. start → PC=0, StackErr=0.
- COM with ComAck in the same cycle → COMFlag=1. ComAck next cycle → COMFlag=0. END → EndFlag=1 and PC frozen across 10 cycles.
- Stall=1 for 3 cycles during JMP → PC unchanged until Stall drops. Assert reset mid-RUN → all outputs 0 asynchronously, without waiting for clk.
